// File: rtl/mac_pkg.sv
// Shared constants and helpers for the Wallace-tree multiply-accumulate block.
// Operand/product widths are fixed by the 8x8 multiplier; accumulator and counter widths are defaults.
package mac_pkg;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    logic [31:0] r;
    if (v >= max) begin
      r = max;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wallace_mac_acc_wallacetree.sv
// Combinational 8x8 unsigned Wallace-tree multiplier (carry-save reduction, one final adder).
// The 64-bit product port keeps the legacy interface; only bits [15:0] carry data.
module wallacetree
  import mac_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [63:0]     p
);

  logic [PROD_W-1:0] pp_s [OP_W];
  logic [PROD_W-1:0] s0_s, c0_s, s1_s, c1_s, s2_s, c2_s, s3_s, c3_s;
  logic [PROD_W-1:0] s4_s, c4_s, s5_s, c5_s, prod_s;

  // 3:2 compressor on whole words; result packs {carry, sum}.
  function automatic logic [2*PROD_W-1:0] csa(input logic [PROD_W-1:0] x,
                                               input logic [PROD_W-1:0] y,
                                               input logic [PROD_W-1:0] z);
    logic [PROD_W-1:0] s;
    logic [PROD_W-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  // partial products, then four reduction layers 8 -> 6 -> 4 -> 3 -> 2
  always_comb begin
    for (int i = 0; i < OP_W; i++) begin
      pp_s[i] = {8'd0, a & {OP_W{b[i]}}} << i;
    end
    {c0_s, s0_s} = csa(pp_s[0], pp_s[1], pp_s[2]);
    {c1_s, s1_s} = csa(pp_s[3], pp_s[4], pp_s[5]);
    {c2_s, s2_s} = csa(s0_s, c0_s, s1_s);
    {c3_s, s3_s} = csa(c1_s, pp_s[6], pp_s[7]);
    {c4_s, s4_s} = csa(s2_s, c2_s, s3_s);
    {c5_s, s5_s} = csa(s4_s, c4_s, c3_s);
    prod_s = s5_s + c5_s;
    p = {48'd0, prod_s};
  end

endmodule

// File: rtl/wallace_mac_acc.sv
// Three-stage multiply-accumulate: operand register, product register, running sum and result.
// A pending result that the consumer has not taken freezes the whole pipeline.
module wallace_mac_acc
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic              v1_r, last1_r, v2_r, last2_r, ovf_r;
  logic [OP_W-1:0]   a1_r, b1_r;
  logic [PROD_W-1:0] p2_r;
  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              stall_s, accept_s, ovf_n_s;
  logic [ACC_W:0]    sum_s;
  logic [CNT_W-1:0]  cnt_n_s;
  logic [63:0]       mult_s;
  logic [PROD_W-1:0] mult_lo_s;
  logic [47:0]       mult_unused_s;

  assign stall_s  = out_valid && !out_ready;
  assign in_ready = !stall_s;
  assign accept_s = in_valid && in_ready;

  wallacetree u_mult (
    .a (a1_r),
    .b (b1_r),
    .p (mult_s)
  );

  assign mult_lo_s     = mult_s[PROD_W-1:0];
  assign mult_unused_s = mult_s[63:PROD_W];

  // next running values for the S3 update
  always_comb begin
    sum_s   = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, p2_r};
    ovf_n_s = ovf_r | sum_s[ACC_W];
    cnt_n_s = CNT_W'(sat_inc(32'(cnt_r), CNT_MAX));
  end

  // S1 operand and S2 product registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      a1_r    <= '0;
      b1_r    <= '0;
      last1_r <= 1'b0;
      v2_r    <= 1'b0;
      p2_r    <= '0;
      last2_r <= 1'b0;
    end else if (!stall_s) begin
      v1_r <= accept_s;
      if (accept_s) begin
        a1_r    <= in_a;
        b1_r    <= in_b;
        last1_r <= in_last;
      end
      v2_r    <= v1_r;
      p2_r    <= mult_lo_s;
      last2_r <= last1_r;
    end
  end

  // S3 running sum and result registers; not stalled implies any held result is being taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      ovf_r     <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall_s) begin
      if (v2_r && last2_r) begin
        out_acc   <= sum_s[ACC_W-1:0];
        out_count <= cnt_n_s;
        out_ovf   <= ovf_n_s;
        out_valid <= 1'b1;
        acc_r     <= '0;
        cnt_r     <= '0;
        ovf_r     <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        if (v2_r) begin
          acc_r <= sum_s[ACC_W-1:0];
          cnt_r <= cnt_n_s;
          ovf_r <= ovf_n_s;
        end
      end
    end
  end

endmodule

// File: doc/wallace_mac_acc.md
# wallace_mac_acc

Pipelined multiply-accumulate stage built around the existing 8x8 `wallacetree` multiplier. It accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake. Each pair is multiplied, and the products of one vector (terminated by `in_last`) are summed into a single result, which is presented with an element count and an overflow flag. It sits between the operand source and any consumer of dot-product results.

## Interface
- `ACC_W`, default 24: accumulator/result width, legal range 16..32.
- `CNT_W`, default 8: element-counter width.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept a pair this cycle.
- `in_a`  in  8  unsigned multiplicand.
- `in_b`  in  8  unsigned multiplier.
- `in_last`  in  1  pair is the final element of the current vector.
- `out_valid`  out  1  result registered and pending.
- `out_ready`  in  1  consumer accepts the result.
- `out_acc`  out  ACC_W  sum of products of the vector, modulo 2^ACC_W.
- `out_count`  out  CNT_W  number of elements in the vector, saturating at 2^CNT_W-1.
- `out_ovf`  out  1  sticky: some partial sum exceeded 2^ACC_W-1.

## Operation
Pipeline stages:
- **S1** operand register: `v1`, `a1`, `b1`, `last1`. Loaded on `in_valid && in_ready`.
- **S2** product register: `v2`, `p2[15:0]`, `last2`. `p2` takes bits [15:0] of the multiplier output; bits [63:16] are ignored.
- **S3** running state and output:
  - Running state: `acc` (ACC_W), `cnt` (CNT_W), `ovf_r`.
  - Output registers: `out_acc`, `out_count`, `out_ovf`, `out_valid`.

Stall and ready:
- `stall = out_valid && !out_ready`.
- `in_ready = !stall`.
- During a stall, every S1/S2/S3 register holds its value.

S3 update when `v2 && !stall`:
- Compute `sum = acc + zero_extend(p2)` at ACC_W+1 bits.
- Compute `ovf_n = ovf_r | sum[ACC_W]`.
- Compute `cnt_n = sat(cnt+1)`.
- If `last2`:
  - Load `out_acc = sum[ACC_W-1:0]`, `out_count = cnt_n`, `out_ovf = ovf_n`, and set `out_valid = 1`.
  - Clear `acc`, `cnt` and `ovf_r` to 0.
- If not `last2`: `acc = sum`, `cnt = cnt_n`, `ovf_r = ovf_n`.

Output handshake:
- `out_valid` clears on `out_valid && out_ready`, unless a new `last2` result loads in the same cycle. In that case it stays 1 and the outputs take the new values.
- `out_acc`, `out_count` and `out_ovf` remain stable while `out_valid && !out_ready`.

Reset:
- Reset values: all valid bits 0, `acc`/`cnt`/`ovf_r` 0, `out_acc`/`out_count`/`out_ovf` 0, `out_valid` 0.
- `in_ready` is 1 out of reset.
- Reset mid-vector discards the partial sum and every in-flight pair. The first pair accepted after reset starts a new vector.

Boundary cases:
- A single-element vector is legal and produces `out_count = 1`.
- `in_last` on consecutive pairs produces back-to-back results, one per cycle, if `out_ready` is held high.
- `cnt` saturates and does not wrap; `acc` wraps modulo 2^ACC_W and sets the overflow flag.

## Timing
- Latency: pair accepted at edge k, then S1 at k, S2 at k+1, S3/outputs at k+2. For a `last` pair, `out_valid` is high in the cycle after edge k+2.
- Throughput: one pair per cycle when not stalled.
- `in_ready` is combinational from `out_valid` and `out_ready` only; it has no path from `in_valid`.
- The multiplier is combinational between S1 and S2 and must close in one clock period.
- Bubbles (`v1`/`v2` = 0) pass through without changing `acc` or `cnt`.

## Structure
- Shared package `mac_pkg`: `PROD_W = 16`, `OP_W = 8`, default `ACC_W`/`CNT_W`, and a saturating-increment function.
- Sub-module: one instance of `wallacetree` (A = `a1`, B = `b1`).
- Everything else stays in `wallace_mac_acc`. No separate FSM module; the control state is the valid/last bits plus `out_valid`.

## Test plan
- Hold `rst_n` = 0 for 2 cycles → `out_valid = 0`, `in_ready = 1`, `out_acc = 0`, `out_count = 0`, `out_ovf = 0`.
- Single pair (255, 255, last) → after 3 edges `out_acc = 65025` (0xFE01), `out_count = 1`, `out_ovf = 0`, `out_valid` high once.
- Back-to-back pairs (3,4), (5,6), (7,8, last) with `out_ready = 1` → `out_acc = 98`, `out_count = 3`, `out_valid` asserted for exactly one cycle.
- Backpressure:
  - Drive `out_ready = 0` while the result 98 is pending and `in_valid` is held → `in_ready = 0`, outputs stable, no pair lost.
  - Then release `out_ready` and send (2, 3, last) → next result is `out_acc = 6`, `out_count = 1`.
- Overflow with `ACC_W = 16`: pairs (255,255), (255,255, last) → `out_acc = 0xFC02`, `out_ovf = 1`. The following vector (1, 1, last) gives `out_acc = 1`, `out_ovf = 0`.
- Reset mid-vector: accept (10,10), (10,10), pull `rst_n` low for 1 cycle, then send (2, 3, last) → `out_acc = 6`, `out_count = 1`, with no earlier result emitted.
